game_countdown_timer: RTL and testbench
=======================================

// Module: game_countdown_timer
// PURPOSE
//  Countdown timer feeding the game FSM: restarts on start_timer, expires after DURATION_S seconds, signals timer_done.
//  Also exports remaining time as binary and 2-digit BCD for the HUD/text overlay renderer downstream.
//  Sits between the game FSM (start_timer out / timer_done in) and the screen overlay path.
// PARAMETERS
//  CLK_HZ      74_250_000  clk_in frequency; prescaler terminal count = CLK_HZ-1
//  DURATION_S  60          game length in seconds; legal range 1..99 (elaborate-time $error outside)
//  WARN_S      10          low-time warning threshold in seconds (used only with TIMER_WARN_EN)
// PORTS
//  clk_in        in   1  system clock
//  rst_in        in   1  asynchronous reset, ACTIVE-LOW
//  start_timer   in   1  1-cycle pulse from game FSM; (re)loads and starts timer from any state
//  pause_in      in   1  level; freezes countdown while high (RUNNING<->PAUSED)
//  abort_in      in   1  1-cycle pulse; return to IDLE, clear outputs (player quit to free roam)
//  timer_done    out  1  level; high in EXPIRED, held until next start_timer/abort_in/reset
//  running       out  1  high in RUNNING only
//  seconds_left  out  7  remaining whole seconds, binary
//  bcd_tens      out  4  tens digit of seconds_left
//  bcd_ones      out  4  ones digit of seconds_left
//  warn          out  1  low-time flag (TIMER_WARN_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (rst_in low, async assert, sync-deassert via 2-flop sync inside block): state=IDLE,
//   prescaler=0, seconds_left=0, bcd_tens=0, bcd_ones=0, timer_done=0, running=0, warn=0.
//  States: IDLE, RUNNING, PAUSED, EXPIRED.
//   IDLE:    start_timer -> RUNNING; load seconds_left=DURATION_S, BCD=DURATION_S/10, %10, prescaler=0.
//   RUNNING: prescaler++ each cycle; at CLK_HZ-1 -> tick: prescaler=0, seconds_left--, BCD decrement
//            (ones==0 -> ones=9, tens--). Tick taking seconds_left 1->0 -> EXPIRED, timer_done=1 same edge.
//            pause_in high -> PAUSED (prescaler, seconds held; tick on that cycle suppressed).
//   PAUSED:  everything held; pause_in low -> RUNNING, prescaler resumes from held value.
//   EXPIRED: seconds_left=0, BCD=00, timer_done=1; waits for start_timer or abort_in.
//  Priority per cycle: abort_in > start_timer > pause_in > tick.
//   start_timer in any state (incl. RUNNING/PAUSED/EXPIRED) reloads and enters RUNNING; timer_done cleared next edge.
//   abort_in in any state -> IDLE with all outputs at reset values.
//  Latency: start_timer sampled at edge N -> running=1, seconds_left=DURATION_S after edge N.
//   First decrement after exactly CLK_HZ RUNNING cycles; expiry DURATION_S*CLK_HZ RUNNING cycles after start.
//  Outputs all registered; no combinational path input->output.
//  Widths: prescaler $clog2(CLK_HZ) bits; BCD maintained incrementally, never via divide at runtime.
//  Invariant: seconds_left == 10*bcd_tens + bcd_ones at every edge.
// CONFIGURATION
//  `TIMER_WARN_EN defined: warn=1 when state in {RUNNING,PAUSED} and 0<seconds_left<=WARN_S, else 0;
//   registered, updates same edge as seconds_left. Overlay uses it to flash digits red.
//  Not defined: warn tied 0, no compare logic; WARN_S unused.
// TESTING  (CLK_HZ=10, DURATION_S=3, WARN_S=1 unless noted)
//  Reset: rst_in low mid-RUNNING -> all outputs 0 asynchronously; after release, stays IDLE without start.
//  Full run: start pulse -> running=1, seconds 3; 3 after 9 cycles, 2 at cycle 10, 1 at 20, 0 and timer_done=1 at 30.
//  Pause: pause_in high cycles 5..24 after start -> first decrement at cycle 30, expiry at cycle 50.
//  Restart: start_timer at cycle 25 (seconds=1) -> seconds=3, timer_done stays 0, expiry at 25+30.
//  Priority: abort_in and start_timer same cycle in EXPIRED -> IDLE, timer_done=0, seconds 0.
//  BCD (DURATION_S=20): tick 20->19 -> tens=1, ones=9; tick 10->9 -> tens=0, ones=9.
//  `TIMER_WARN_EN: warn=1 exactly while seconds_left==1; 0 in EXPIRED; 0 throughout when macro undefined.

Source files
------------

// File: rtl/game_countdown_timer_if.sv
// Signal bundle between the game FSM (master) and the countdown timer (slave).
// state_dbg exposes the timer FSM encoding for observation.
interface game_countdown_timer_if;
  // Control: start_timer and abort_in are single-cycle pulses. pause_in is a level
  // that is sampled on every clock edge. All timer outputs are registered levels.
  logic       start_timer;
  logic       pause_in;
  logic       abort_in;
  logic       timer_done;
  logic       running;
  logic [6:0] seconds_left;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       warn;
  logic [1:0] state_dbg;

  modport master (
    output start_timer, pause_in, abort_in,
    input  timer_done, running, seconds_left, bcd_tens, bcd_ones, warn, state_dbg
  );

  modport slave (
    input  start_timer, pause_in, abort_in,
    output timer_done, running, seconds_left, bcd_tens, bcd_ones, warn, state_dbg
  );
endinterface

// File: rtl/game_countdown_timer.sv
// Game countdown timer with binary and incremental 2-digit BCD remaining time.
// Optional low-time warning flag enabled by defining TIMER_WARN_EN.
module game_countdown_timer #(
  parameter int CLK_HZ     = 74_250_000,
  parameter int DURATION_S = 60,
  parameter int WARN_S     = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  game_countdown_timer_if.slave tmr
);

  if (DURATION_S < 1 || DURATION_S > 99) begin : g_bad_duration
    $error("game_countdown_timer: DURATION_S must be in 1..99");
  end
  if (WARN_S < 0 || WARN_S > 99) begin : g_bad_warn
    $error("game_countdown_timer: WARN_S must be in 0..99");
  end

  localparam int          PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
  localparam logic [6:0]  DUR_V  = 7'(DURATION_S);
  localparam logic [3:0]  TENS_V = 4'(DURATION_S / 10);
  localparam logic [3:0]  ONES_V = 4'(DURATION_S % 10);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [PW-1:0] prescaler;
  logic [6:0]    seconds_left;
  logic [3:0]    bcd_tens;
  logic [3:0]    bcd_ones;
  logic          timer_done;
  logic          running;
  logic          live;
  logic          tick;
  logic [6:0]    sec_m1;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign live   = (state == S_RUNNING) || (state == S_PAUSED);
  assign tick   = (prescaler == PRE_TC);
  assign sec_m1 = seconds_left - 7'd1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      prescaler    <= '0;
      seconds_left <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      timer_done   <= 1'b0;
      running      <= 1'b0;
    end else if (tmr.abort_in) begin
      state        <= S_IDLE;
      prescaler    <= '0;
      seconds_left <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      timer_done   <= 1'b0;
      running      <= 1'b0;
    end else if (tmr.start_timer) begin
      state        <= S_RUNNING;
      prescaler    <= '0;
      seconds_left <= DUR_V;
      bcd_tens     <= TENS_V;
      bcd_ones     <= ONES_V;
      timer_done   <= 1'b0;
      running      <= 1'b1;
    end else if (live && tmr.pause_in) begin
      state   <= S_PAUSED;
      running <= 1'b0;
    end else if (live) begin
      // The resume edge also counts, so a pause costs exactly its own cycles.
      state   <= S_RUNNING;
      running <= 1'b1;
      if (tick) begin
        prescaler    <= '0;
        seconds_left <= sec_m1;
        if (bcd_ones == 4'd0) begin
          bcd_ones <= 4'd9;
          bcd_tens <= bcd_tens - 4'd1;
        end else begin
          bcd_ones <= bcd_ones - 4'd1;
        end
        if (seconds_left == 7'd1) begin
          state      <= S_EXPIRED;
          running    <= 1'b0;
          timer_done <= 1'b1;
        end
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

`ifdef TIMER_WARN_EN
  localparam logic [6:0] WARN_V = 7'(WARN_S);
  logic warn_q;

  // Follows the same branch priority as the FSM so it moves with seconds_left.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                        warn_q <= 1'b0;
    else if (tmr.abort_in)             warn_q <= 1'b0;
    else if (tmr.start_timer)          warn_q <= (DUR_V <= WARN_V);
    else if (live && !tmr.pause_in)    warn_q <= tick ? ((seconds_left != 7'd1) && (sec_m1 <= WARN_V))
                                                      : ((seconds_left != 7'd0) && (seconds_left <= WARN_V));
    else if (!live)                    warn_q <= 1'b0;
  end
  assign tmr.warn = warn_q;
`else
  assign tmr.warn = 1'b0;
`endif

  assign tmr.timer_done   = timer_done;
  assign tmr.running      = running;
  assign tmr.seconds_left = seconds_left;
  assign tmr.bcd_tens     = bcd_tens;
  assign tmr.bcd_ones     = bcd_ones;
  assign tmr.state_dbg    = state;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: a 3 s timer at 10 Hz and a 20 s timer at 2 Hz.
// Expected output words are queued with a cycle stamp and compared when that cycle is reached.
module tb_game_countdown_timer;

  localparam int W = 18;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  game_countdown_timer_if ifc1();
  game_countdown_timer_if ifc2();

  game_countdown_timer #(.CLK_HZ(10), .DURATION_S(3), .WARN_S(1)) u_dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .tmr(ifc1)
  );
  game_countdown_timer #(.CLK_HZ(2), .DURATION_S(20), .WARN_S(5)) u_dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .tmr(ifc2)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           sel_q[$];
  string        tag_q[$];
  int           cyc;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] obs(input int sel);
    if (sel == 1)
      return {ifc1.timer_done, ifc1.running, ifc1.seconds_left, ifc1.bcd_tens, ifc1.bcd_ones, ifc1.warn};
    return {ifc2.timer_done, ifc2.running, ifc2.seconds_left, ifc2.bcd_tens, ifc2.bcd_ones, ifc2.warn};
  endfunction

  function automatic logic [W-1:0] mk(input logic done, input logic run, input logic live,
                                      input int sec, input int warn_s);
    logic w;
    w = live && (sec > 0) && (sec <= warn_s);
`ifndef TIMER_WARN_EN
    w = 1'b0;
`endif
    return {done, run, 7'(sec), 4'(sec / 10), 4'(sec % 10), w};
  endfunction

  task automatic expect_at(input string tag, input int k, input int sel, input logic [W-1:0] val);
    tag_q.push_back(tag);
    cyc_q.push_back(k);
    sel_q.push_back(sel);
    exp_q.push_back(val);
  endtask

  task automatic drain();
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      void'(cyc_q.pop_front());
      check_eq(tag_q.pop_front(), obs(sel_q.pop_front()), exp_q.pop_front());
    end
  endtask

  task automatic advance_to(input int k);
    while (cyc < k) begin
      @(posedge clk_in);
      #1;
      cyc++;
      drain();
    end
  endtask

  // driver tasks
  task automatic pulse_start(input int sel);
    if (sel == 1) ifc1.start_timer = 1'b1;
    else          ifc2.start_timer = 1'b1;
    @(posedge clk_in);
    #1;
    ifc1.start_timer = 1'b0;
    ifc2.start_timer = 1'b0;
    cyc = 0;
    drain();
  endtask

  task automatic pulse_abort();
    ifc1.abort_in = 1'b1;
    @(posedge clk_in);
    #1;
    ifc1.abort_in = 1'b0;
  endtask

  initial begin
    ifc1.start_timer = 1'b0; ifc1.pause_in = 1'b0; ifc1.abort_in = 1'b0;
    ifc2.start_timer = 1'b0; ifc2.pause_in = 1'b0; ifc2.abort_in = 1'b0;
    cyc = 0;

    repeat (3) @(posedge clk_in);
    #1;
    check_eq("reset_dut1", obs(1), '0);
    check_eq("reset_dut2", obs(2), '0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    check_eq("idle_after_reset", obs(1), '0);

    // full run
    expect_at("run_start", 0,  1, mk(0, 1, 1, 3, 1));
    expect_at("run_c9",    9,  1, mk(0, 1, 1, 3, 1));
    expect_at("run_c10",   10, 1, mk(0, 1, 1, 2, 1));
    expect_at("run_c19",   19, 1, mk(0, 1, 1, 2, 1));
    expect_at("run_c20",   20, 1, mk(0, 1, 1, 1, 1));
    expect_at("run_c29",   29, 1, mk(0, 1, 1, 1, 1));
    expect_at("run_expire",30, 1, mk(1, 0, 0, 0, 1));
    expect_at("run_hold",  35, 1, mk(1, 0, 0, 0, 1));
    pulse_start(1);
    advance_to(35);
    check_eq("state_expired", 18'(ifc1.state_dbg), 18'd3);

    // abort beats start in the same cycle
    ifc1.start_timer = 1'b1;
    pulse_abort();
    ifc1.start_timer = 1'b0;
    check_eq("abort_over_start", obs(1), '0);
    check_eq("state_idle", 18'(ifc1.state_dbg), 18'd0);

    // pause sampled high on edges 5..24
    expect_at("pause_c4", 4, 1, mk(0, 1, 1, 3, 1));
    pulse_start(1);
    advance_to(4);
    ifc1.pause_in = 1'b1;
    expect_at("pause_c5",  5,  1, mk(0, 0, 1, 3, 1));
    expect_at("pause_c24", 24, 1, mk(0, 0, 1, 3, 1));
    advance_to(24);
    ifc1.pause_in = 1'b0;
    expect_at("resume_c25", 25, 1, mk(0, 1, 1, 3, 1));
    expect_at("resume_c29", 29, 1, mk(0, 1, 1, 3, 1));
    expect_at("resume_c30", 30, 1, mk(0, 1, 1, 2, 1));
    expect_at("resume_c40", 40, 1, mk(0, 1, 1, 1, 1));
    expect_at("resume_c49", 49, 1, mk(0, 1, 1, 1, 1));
    expect_at("resume_exp", 50, 1, mk(1, 0, 0, 0, 1));
    advance_to(50);

    // restart from EXPIRED, then again while one second remains
    expect_at("rs_c0",  0,  1, mk(0, 1, 1, 3, 1));
    expect_at("rs_c25", 25, 1, mk(0, 1, 1, 1, 1));
    pulse_start(1);
    advance_to(25);
    expect_at("rs2_c0",  0,  1, mk(0, 1, 1, 3, 1));
    expect_at("rs2_c29", 29, 1, mk(0, 1, 1, 1, 1));
    expect_at("rs2_exp", 30, 1, mk(1, 0, 0, 0, 1));
    pulse_start(1);
    advance_to(30);

    // async reset mid-run
    expect_at("rst_pre", 12, 1, mk(0, 1, 1, 2, 1));
    pulse_start(1);
    advance_to(12);
    #2;
    rst_in = 1'b0;
    #1;
    check_eq("async_reset", obs(1), '0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    check_eq("idle_no_start", obs(1), '0);

    // BCD borrow on the 20 s timer
    expect_at("bcd_c0",  0,  2, mk(0, 1, 1, 20, 5));
    expect_at("bcd_19",  2,  2, mk(0, 1, 1, 19, 5));
    expect_at("bcd_10",  21, 2, mk(0, 1, 1, 10, 5));
    expect_at("bcd_9",   22, 2, mk(0, 1, 1, 9, 5));
    expect_at("bcd_5",   30, 2, mk(0, 1, 1, 5, 5));
    expect_at("bcd_1",   38, 2, mk(0, 1, 1, 1, 5));
    expect_at("bcd_exp", 40, 2, mk(1, 0, 0, 0, 5));
    pulse_start(2);
    advance_to(40);

    check_eq("queue_empty", 18'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
